deser_capture: RTL and testbench
================================

Name: deser_capture

Overview:
- Multi-lane, parametrised deserialiser. Generalises the single-bit shift-then-load capture register.
- Accepts LANES bits per qualified clock. Auto-captures a full frame after WIDTH/LANES beats, or a partial frame on an explicit flush.
- Presents the frame in an output holding register with a valid/ready handshake and sticky overrun reporting.
- Sits between the fast serial readout front-end and the downstream packer/FIFO.

Parameters:
- WIDTH, 512: frame width in bits. Must be a multiple of LANES.
- LANES, 1: bits accepted per beat. Legal values 1, 2, 4, 8.
- MSB_FIRST, 1: 1 = shift toward MSB, insert at LSBs. 0 = shift toward LSB, insert at MSBs.
- Derived: DEPTH = WIDTH/LANES; CW = clog2(DEPTH+1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- shift_en  in  1  qualifies shift_in this cycle (one beat).
- shift_in  in  LANES  beat data.
- flush  in  1  capture the current partial frame.
- out_ready  in  1  downstream accepts the held frame.
- clear_ovr  in  1  clears the overrun flag.
- data_out  out  WIDTH  held frame.
- out_valid  out  1  data_out holds an unconsumed frame.
- out_beats  out  CW  beats contained in the held frame (1..DEPTH).
- overrun  out  1  sticky: at least one frame was dropped.

Behaviour:
- Reset (reset_n=0 at edge) clears everything:
  - internal shift register = 0 and beat counter = 0;
  - data_out = 0, out_valid = 0, out_beats = 0, overrun = 0.
  - Reset mid-frame discards the partial frame; no capture occurs.
- Shift, on each edge with shift_en=1:
  - MSB_FIRST=1: sr <= {sr[WIDTH-LANES-1:0], shift_in}.
  - MSB_FIRST=0: sr <= {shift_in, sr[WIDTH-1:LANES]}.
  - cnt increments by 1.
- Completion event C occurs on an edge when either:
  - shift_en=1 and cnt==DEPTH-1 (auto), or
  - flush=1 and (cnt>0 or shift_en=1) (flush).
- The captured value is the next-state sr, i.e. the beat arriving that cycle is included.
  - With the bits not yet shifted in left at 0, a partial frame is placed at the insertion end, zero-padded on the far side.
- Captured beat count = cnt + shift_en.
- On C, sr and cnt reset to 0 at the same edge. Shifting continues uninterrupted next cycle, so there are no dead cycles between frames.
- flush with cnt==0 and shift_en=0 is a no-op: no empty frames.
- Output slot is free when out_valid=0 or (out_valid & out_ready).
- On C with slot free:
  - data_out and out_beats are loaded;
  - out_valid=1 from the next cycle (latency 1 edge from the final beat).
- On C with slot not free:
  - the frame is dropped and data_out is untouched;
  - overrun <= 1.
- Pop (out_valid & out_ready) with no C: out_valid <= 0. data_out and out_beats retain their values.
- Pop and C on the same edge: out_valid stays 1 with the new frame (back-to-back, no bubble).
- data_out must stay stable while out_valid=1 and no pop occurs.
- overrun is sticky and is cleared by clear_ovr.
  - If clear_ovr and a new drop occur on the same edge, overrun = 1 (set wins).

Test Plan (WIDTH=8, LANES=2, MSB_FIRST=1, DEPTH=4 unless noted):
- Full frame: 4 consecutive beats 2'b11, 2'b00, 2'b10, 2'b01, out_ready=0.
  - Required: next cycle data_out=8'b11001001, out_valid=1, out_beats=4.
- Back-to-back: out_ready=1 and a second frame of beats 01,01,01,01 streamed immediately.
  - Required: out_valid stays 1 across the pop edge; data_out=8'h55; no overrun.
- Partial flush: beats 10, 11, then flush=1 with shift_en=0.
  - Required: data_out=8'b00001011, out_beats=2.
  - flush again with no beats: no new out_valid.
- Overrun: hold out_ready=0, stream two full frames.
  - Required: data_out keeps the first frame; overrun=1.
  - clear_ovr pulse: overrun=0.
  - clear_ovr coincident with a third drop: overrun stays 1.
- MSB_FIRST=0, LANES=1, WIDTH=8: serial 1,0,0,0,0,0,0,0.
  - Required: data_out=8'h01.
  - Reset asserted after 5 beats: all outputs 0; the next 8 beats form a clean frame.

Source files
------------

// File: rtl/deser_capture.sv
// deser_capture: multi-lane deserialiser with auto/flush frame capture.
// Shifts LANES bits per qualified beat into a WIDTH-bit shift register.
// A frame is captured after WIDTH/LANES beats, or early on flush. It is
// presented in a holding register with a valid/ready handshake. A frame
// that completes while the holding register is still occupied is dropped,
// and the sticky overrun flag is set.
//
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   synchronous active-low reset
//   shift_en   in   shift_in carries one beat this cycle
//   shift_in   in   LANES-bit beat data
//   flush      in   capture the current partial frame
//   out_ready  in   downstream accepts the held frame
//   clear_ovr  in   clears the overrun flag
//   data_out   out  held frame
//   out_valid  out  data_out holds an unconsumed frame
//   out_beats  out  number of beats in the held frame (1..DEPTH)
//   overrun    out  sticky: at least one frame was dropped
module deser_capture #(
  parameter int unsigned WIDTH     = 512,
  parameter int unsigned LANES     = 1,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                shift_en,
  input  logic [LANES-1:0]                    shift_in,
  input  logic                                flush,
  input  logic                                out_ready,
  input  logic                                clear_ovr,
  output logic [WIDTH-1:0]                    data_out,
  output logic                                out_valid,
  output logic [$clog2(WIDTH/LANES+1)-1:0]    out_beats,
  output logic                                overrun
);

  localparam int unsigned DEPTH = WIDTH / LANES;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    beats_q, beats_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic [WIDTH-1:0] sr_shift;
  logic [WIDTH-1:0] sr_next;
  logic [CW-1:0]    beats_cap;
  logic             auto_done;
  logic             flush_done;
  logic             complete;
  logic             slot_free;
  logic             pop;

  // Shift direction; a single-beat frame is just the incoming beat
  generate
    if (DEPTH == 1) begin : g_single
      assign sr_shift = shift_in;
    end else if (MSB_FIRST != 0) begin : g_msb
      assign sr_shift = {sr_q[WIDTH-LANES-1:0], shift_in};
    end else begin : g_lsb
      assign sr_shift = {shift_in, sr_q[WIDTH-1:LANES]};
    end
  endgenerate

  // Capture sees the register as it will be after this cycle's beat
  assign sr_next    = shift_en ? sr_shift : sr_q;
  assign beats_cap  = cnt_q + CW'(shift_en);
  assign auto_done  = shift_en && (cnt_q == CW'(DEPTH - 1));
  assign flush_done = flush && ((cnt_q != '0) || shift_en);
  assign complete   = auto_done || flush_done;
  assign pop        = valid_q && out_ready;
  assign slot_free  = !valid_q || out_ready;

  // Next-state: shifting, frame capture, handshake and overrun tracking
  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    beats_d = beats_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    if (shift_en) begin
      sr_d  = sr_shift;
      cnt_d = cnt_q + CW'(1);
    end

    // Clear first so a simultaneous drop below wins
    if (clear_ovr) begin
      ovr_d = 1'b0;
    end

    if (complete) begin
      sr_d  = '0;
      cnt_d = '0;
      if (slot_free) begin
        data_d  = sr_next;
        beats_d = beats_cap;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      beats_q <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      beats_q <= beats_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign out_beats = beats_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_deser_capture.sv
// Directed bench for deser_capture: a WIDTH=8/LANES=2/MSB_FIRST=1 instance (a_*)
// and a WIDTH=8/LANES=1/MSB_FIRST=0 instance (b_*), sharing clock and reset.
module tb_deser_capture;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;

  logic       a_shift_en = 1'b0;
  logic [1:0] a_shift_in = '0;
  logic       a_flush = 1'b0;
  logic       a_out_ready = 1'b0;
  logic       a_clear_ovr = 1'b0;
  logic [7:0] a_data_out;
  logic       a_out_valid;
  logic [2:0] a_out_beats;
  logic       a_overrun;

  logic       b_shift_en = 1'b0;
  logic [0:0] b_shift_in = '0;
  logic       b_flush = 1'b0;
  logic       b_out_ready = 1'b0;
  logic       b_clear_ovr = 1'b0;
  logic [7:0] b_data_out;
  logic       b_out_valid;
  logic [3:0] b_out_beats;
  logic       b_overrun;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  deser_capture #(.WIDTH(8), .LANES(2), .MSB_FIRST(1)) u_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .shift_en  (a_shift_en),
    .shift_in  (a_shift_in),
    .flush     (a_flush),
    .out_ready (a_out_ready),
    .clear_ovr (a_clear_ovr),
    .data_out  (a_data_out),
    .out_valid (a_out_valid),
    .out_beats (a_out_beats),
    .overrun   (a_overrun)
  );

  deser_capture #(.WIDTH(8), .LANES(1), .MSB_FIRST(0)) u_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .shift_en  (b_shift_en),
    .shift_in  (b_shift_in),
    .flush     (b_flush),
    .out_ready (b_out_ready),
    .clear_ovr (b_clear_ovr),
    .data_out  (b_data_out),
    .out_valid (b_out_valid),
    .out_beats (b_out_beats),
    .overrun   (b_overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_beat(input logic [1:0] d);
    a_shift_en = 1'b1;
    a_shift_in = d;
    step();
    a_shift_en = 1'b0;
  endtask

  task automatic b_beat(input logic d);
    b_shift_en = 1'b1;
    b_shift_in = d;
    step();
    b_shift_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset
    reset_n = 1'b0;
    step();
    step();
    check("rst_a_data",  32'(a_data_out),  32'h00);
    check("rst_a_valid", 32'(a_out_valid), 32'h0);
    check("rst_a_beats", 32'(a_out_beats), 32'h0);
    check("rst_a_ovr",   32'(a_overrun),   32'h0);
    check("rst_b_data",  32'(b_data_out),  32'h00);
    check("rst_b_valid", 32'(b_out_valid), 32'h0);
    reset_n = 1'b1;
    step();

    // Full frame 11,00,10,01 -> 8'b11001001
    a_out_ready = 1'b0;
    a_beat(2'b11);
    a_beat(2'b00);
    a_beat(2'b10);
    check("full_pre_valid", 32'(a_out_valid), 32'h0);
    a_beat(2'b01);
    check("full_data",  32'(a_data_out),  32'hC9);
    check("full_valid", 32'(a_out_valid), 32'h1);
    check("full_beats", 32'(a_out_beats), 32'h4);

    // Back-to-back: pop coincides with completion of the 0x55 frame
    a_beat(2'b01);
    a_beat(2'b01);
    a_beat(2'b01);
    check("b2b_hold_data",  32'(a_data_out),  32'hC9);
    check("b2b_hold_valid", 32'(a_out_valid), 32'h1);
    a_out_ready = 1'b1;
    a_beat(2'b01);
    check("b2b_valid", 32'(a_out_valid), 32'h1);
    check("b2b_data",  32'(a_data_out),  32'h55);
    check("b2b_beats", 32'(a_out_beats), 32'h4);
    check("b2b_ovr",   32'(a_overrun),   32'h0);
    step();  // pop without a new frame
    check("pop_valid", 32'(a_out_valid), 32'h0);
    check("pop_data",  32'(a_data_out),  32'h55);
    a_out_ready = 1'b0;

    // Partial flush: 10,11 then flush -> 8'b00001011
    a_beat(2'b10);
    a_beat(2'b11);
    a_flush = 1'b1;
    step();
    a_flush = 1'b0;
    check("flush_data",  32'(a_data_out),  32'h0B);
    check("flush_beats", 32'(a_out_beats), 32'h2);
    check("flush_valid", 32'(a_out_valid), 32'h1);
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
    check("flush_pop_valid", 32'(a_out_valid), 32'h0);
    a_flush = 1'b1;  // empty flush is a no-op
    step();
    a_flush = 1'b0;
    check("empty_flush_valid", 32'(a_out_valid), 32'h0);
    check("empty_flush_data",  32'(a_data_out),  32'h0B);

    // Flush together with a beat from an empty register: one-beat frame
    a_flush = 1'b1;
    a_beat(2'b11);
    a_flush = 1'b0;
    check("flush1_data",  32'(a_data_out),  32'h03);
    check("flush1_beats", 32'(a_out_beats), 32'h1);
    check("flush1_valid", 32'(a_out_valid), 32'h1);
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;

    // Overrun: 0xAA held, 0xFF dropped
    for (int i = 0; i < 4; i++) a_beat(2'b10);
    check("ovr_first_data", 32'(a_data_out), 32'hAA);
    for (int i = 0; i < 4; i++) a_beat(2'b11);
    check("ovr_keep_data", 32'(a_data_out),  32'hAA);
    check("ovr_flag",      32'(a_overrun),   32'h1);
    check("ovr_valid",     32'(a_out_valid), 32'h1);
    a_clear_ovr = 1'b1;
    step();
    a_clear_ovr = 1'b0;
    check("ovr_cleared", 32'(a_overrun), 32'h0);
    for (int i = 0; i < 3; i++) a_beat(2'b01);
    check("ovr_third_pre", 32'(a_overrun), 32'h0);
    a_clear_ovr = 1'b1;
    a_beat(2'b01);
    a_clear_ovr = 1'b0;
    check("ovr_set_wins",  32'(a_overrun),  32'h1);
    check("ovr_final_data", 32'(a_data_out), 32'hAA);
    check("ovr_final_beats", 32'(a_out_beats), 32'h4);

    // LSB-first serial: 1,0,0,0,0,0,0,0 -> 8'h01
    b_beat(1'b1);
    for (int i = 0; i < 7; i++) b_beat(1'b0);
    check("lsb_data",  32'(b_data_out),  32'h01);
    check("lsb_valid", 32'(b_out_valid), 32'h1);
    check("lsb_beats", 32'(b_out_beats), 32'h8);
    b_out_ready = 1'b1;
    step();
    b_out_ready = 1'b0;

    // LSB-first partial: 1,0,1 then flush -> 8'hA0
    b_beat(1'b1);
    b_beat(1'b0);
    b_beat(1'b1);
    b_flush = 1'b1;
    step();
    b_flush = 1'b0;
    check("lsb_part_data",  32'(b_data_out),  32'hA0);
    check("lsb_part_beats", 32'(b_out_beats), 32'h3);
    b_out_ready = 1'b1;
    step();
    b_out_ready = 1'b0;

    // Reset after 5 beats discards the partial frame
    for (int i = 0; i < 5; i++) b_beat(1'b1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("mid_rst_b_data",  32'(b_data_out),  32'h00);
    check("mid_rst_b_valid", 32'(b_out_valid), 32'h0);
    check("mid_rst_b_beats", 32'(b_out_beats), 32'h0);
    check("mid_rst_b_ovr",   32'(b_overrun),   32'h0);
    check("mid_rst_a_ovr",   32'(a_overrun),   32'h0);
    b_beat(1'b1);
    b_beat(1'b1);
    for (int i = 0; i < 5; i++) b_beat(1'b0);
    check("clean_pre_valid", 32'(b_out_valid), 32'h0);
    b_beat(1'b0);
    check("clean_data",  32'(b_data_out),  32'h03);
    check("clean_valid", 32'(b_out_valid), 32'h1);
    check("clean_beats", 32'(b_out_beats), 32'h8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
